console_mux_hub: RTL and testbench



---
 rtl/console_mux_hub.sv | 159 +++++++++++++++
 tb/tb_console_mux_hub.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/console_mux_hub.sv
// Multi-channel UART console hub: per-channel byte FIFOs arbitrated onto one
// channel-tagged stream, plus a free-running cycle counter and log-window enable.
module console_mux_hub #(
    parameter int NCH          = 4,
    parameter int DEPTH        = 16,
    parameter int CW           = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int LINE_TIMEOUT = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   in_valid,
    input  logic [8*NCH-1:0] in_ch,
    input  logic             line_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_ch,
    output logic [CW-1:0]    out_chan,
    output logic             out_eol,
    output logic [NCH-1:0]   overflow,
    input  logic [NCH-1:0]   overflow_clr,
    input  logic [63:0]      log_begin,
    input  logic [63:0]      log_end,
    output logic             log_en,
    output logic [63:0]      cycle
);
    localparam int unsigned NCH_U = NCH;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (LINE_TIMEOUT > 1) ? $clog2(LINE_TIMEOUT) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] gnt, gnt_nxt, rr, rr_nxt, cidx;
    logic          mode, mode_nxt, found;
    logic [TW-1:0] tcount, tcount_nxt;

    logic [7:0]     mem [NCH][DEPTH];
    logic [PW-1:0]  wr_ptr [NCH];
    logic [PW-1:0]  rd_ptr [NCH];
    logic [NCH-1:0] empty, full, pop, push;
    logic [7:0]     head, last_ch;
    logic [CW-1:0]  last_chan;

    always_comb begin
        for (int unsigned i = 0; i < NCH_U; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            pop[i]   = (state == GRANT) && (gnt == CW'(i)) && !empty[i] && out_ready;
            push[i]  = reset && in_valid[i] && (!full[i] || pop[i]);
        end
    end

    assign head      = mem[gnt][rd_ptr[gnt][AW-1:0]];
    assign out_valid = (state == GRANT) && !empty[gnt];
    assign out_ch    = out_valid ? head : last_ch;
    assign out_chan  = out_valid ? gnt : last_chan;
    assign out_eol   = (out_ch == 8'h0A);

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NCH_U; i++)
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_ch[8*i +: 8];
    end

    // A drop sets the sticky flag even when a clear arrives in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH_U; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH_U; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (in_valid[i] && full[i] && !pop[i]) overflow[i] <= 1'b1;
                else if (overflow_clr[i])              overflow[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= '0;
            rr     <= CW'(NCH - 1);
            mode   <= 1'b0;
            tcount <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr     <= rr_nxt;
            mode   <= mode_nxt;
            tcount <= tcount_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_nxt     = rr;
        mode_nxt   = mode;
        tcount_nxt = tcount;
        found      = 1'b0;
        cidx       = '0;
        case (state)
            IDLE: begin
                for (int unsigned k = 1; k <= NCH_U; k++) begin
                    cidx = CW'((32'(rr) + k) % NCH_U);
                    if (!found && !empty[cidx]) begin
                        found   = 1'b1;
                        gnt_nxt = cidx;
                    end
                end
                if (found) begin
                    rr_nxt     = gnt_nxt;
                    mode_nxt   = line_mode;
                    tcount_nxt = '0;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (out_valid) begin
                    tcount_nxt = '0;
                    if (out_ready && (!mode || head == 8'h0A)) state_nxt = IDLE;
                end else if (tcount == TW'(LINE_TIMEOUT - 1)) begin
                    tcount_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    tcount_nxt = tcount + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output tag and byte hold their last presented values through empty cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_ch   <= '0;
            last_chan <= '0;
        end else if (out_valid) begin
            last_ch   <= head;
            last_chan <= gnt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle  <= '0;
            log_en <= 1'b0;
        end else begin
            cycle  <= cycle + 64'd1;
            log_en <= (cycle >= log_begin) && (cycle < log_end);
        end
    end
endmodule

// File: tb/tb_console_mux_hub.sv
// Directed and randomized checks of console_mux_hub against queue-based expectations.
module tb_console_mux_hub;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int LTO   = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [NCH-1:0]   in_valid;
    logic [8*NCH-1:0] in_ch;
    logic             line_mode;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_ch;
    logic [CW-1:0]    out_chan;
    logic             out_eol;
    logic [NCH-1:0]   overflow;
    logic [NCH-1:0]   overflow_clr;
    logic [63:0]      log_begin;
    logic [63:0]      log_end;
    logic             log_en;
    logic [63:0]      cycle;

    console_mux_hub #(.NCH(NCH), .DEPTH(DEPTH), .CW(CW), .LINE_TIMEOUT(LTO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
        .line_mode(line_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_chan(out_chan), .out_eol(out_eol),
        .overflow(overflow), .overflow_clr(overflow_clr),
        .log_begin(log_begin), .log_end(log_end), .log_en(log_en), .cycle(cycle)
    );

    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        in_valid     = '0;
        in_ch        = '0;
        overflow_clr = '0;
    endtask

    task automatic push(input int c, input logic [7:0] b);
        in_valid[c]     = 1'b1;
        in_ch[8*c +: 8] = b;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_in();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic exp_out(input string tag, input logic v, input int c, input logic [7:0] b);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".chan"},  64'(out_chan),  64'(c));
        chk({tag, ".ch"},    64'(out_ch),    64'(b));
        chk({tag, ".eol"},   64'(out_eol),   64'(b == 8'h0A));
    endtask

    logic [7:0]  q [NCH][$];
    logic [NCH-1:0] exp_ovf;
    logic [63:0] exp_cyc;
    logic        nlog, prev_stall;
    logic [7:0]  prev_ch;
    logic [CW-1:0] prev_chan;
    int          got, c, remaining;

    initial begin
        reset = 1'b0; clear_in(); line_mode = 1'b0; out_ready = 1'b0;
        log_begin = '0; log_end = '0;

        // Reset / idle
        repeat (5) tick();
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.ovf",   64'(overflow),  64'(0));
        chk("rst.cycle", cycle,          64'(0));
        chk("rst.log",   64'(log_en),    64'(0));
        chk("rst.ch",    64'(out_ch),    64'(0));
        chk("rst.chan",  64'(out_chan),  64'(0));
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("cycle.inc", cycle, 64'(k));
        end

        // Byte round-robin
        do_reset(); out_ready = 1'b1; line_mode = 1'b0;
        push(0, "A"); push(2, "C"); tick();
        exp_out("rr1", 0, 0, 8'h00);
        clear_in(); push(0, "B"); push(2, "D"); tick();
        clear_in(); exp_out("rr2", 1, 0, "A");
        tick(); exp_out("rr3", 0, 0, "A");
        tick(); exp_out("rr4", 1, 2, "C");
        tick(); exp_out("rr5", 0, 2, "C");
        tick(); exp_out("rr6", 1, 0, "B");
        tick(); exp_out("rr7", 0, 0, "B");
        tick(); exp_out("rr8", 1, 2, "D");
        tick(); exp_out("rr9", 0, 2, "D");

        // Line atomic; line_mode changes mid-grant must not matter
        do_reset(); out_ready = 1'b1; line_mode = 1'b1;
        push(1, "h"); push(3, "y"); tick();
        exp_out("ln1", 0, 0, 8'h00);
        clear_in(); push(1, "i"); push(3, "o"); tick();
        exp_out("ln2", 1, 1, "h");
        line_mode = 1'b0;
        clear_in(); push(1, 8'h0A); push(3, 8'h0A); tick();
        clear_in(); exp_out("ln3", 1, 1, "i");
        tick(); exp_out("ln4", 1, 1, 8'h0A);
        line_mode = 1'b1;
        tick(); exp_out("ln5", 0, 1, 8'h0A);
        tick(); exp_out("ln6", 1, 3, "y");
        tick(); exp_out("ln7", 1, 3, "o");
        tick(); exp_out("ln8", 1, 3, 8'h0A);
        tick(); exp_out("ln9", 0, 3, 8'h0A);

        // Line-mode timeout
        do_reset(); out_ready = 1'b1; line_mode = 1'b1;
        push(0, "a"); push(1, "x"); tick();
        exp_out("to1", 0, 0, 8'h00);
        clear_in(); push(0, "b"); push(1, 8'h0A); tick();
        clear_in(); exp_out("to2", 1, 0, "a");
        tick(); exp_out("to3", 1, 0, "b");
        for (int k = 4; k <= 12; k++) begin
            tick(); exp_out("to.gap", 0, 0, "b");
        end
        tick(); exp_out("to13", 1, 1, "x");
        tick(); exp_out("to14", 1, 1, 8'h0A);
        tick(); exp_out("to15", 0, 1, 8'h0A);

        // Overflow and backpressure
        do_reset(); out_ready = 1'b0; line_mode = 1'b0;
        for (int k = 0; k < 20; k++) begin
            clear_in(); push(2, 8'(8'h40 + k)); tick();
            chk("ovf.flag", 64'(overflow), (k >= 16) ? 64'h4 : 64'h0);
            if (k >= 1) exp_out("ovf.stall", 1, 2, 8'h40);
        end
        clear_in(); push(2, 8'hEE); overflow_clr = 4'b0100; tick();
        chk("ovf.setwins", 64'(overflow), 64'h4);
        clear_in(); overflow_clr = 4'b0100; tick();
        chk("ovf.clr", 64'(overflow), 64'h0);
        clear_in(); out_ready = 1'b1; got = 0;
        for (int t = 0; t < 80; t++) begin
            if (out_valid) begin
                if (got < 16) begin
                    chk("ovf.order", 64'(out_ch), 64'(8'h40 + got));
                    chk("ovf.chan",  64'(out_chan), 64'(2));
                end else begin
                    chk("ovf.extra", 64'(out_valid), 64'(0));
                end
                got++;
            end
            tick();
        end
        chk("ovf.count", 64'(got), 64'(16));

        // Log window
        out_ready = 1'b0; log_begin = 64'd10; log_end = 64'd20;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk("log.cycle", cycle, 64'(k));
            chk("log.en", 64'(log_en), 64'(k >= 11 && k <= 20));
        end
        log_begin = 64'd20; log_end = 64'd10;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk("log.empty", 64'(log_en), 64'(0));
        end
        log_begin = 64'd0; log_end = 64'd1000;
        do_reset();
        push(1, "Z"); tick(); clear_in(); tick(); tick();
        chk("mid.valid", 64'(out_valid), 64'(1));
        chk("mid.log",   64'(log_en),    64'(1));
        reset = 1'b0; tick();
        chk("mid.cycle", cycle,          64'(0));
        chk("mid.log0",  64'(log_en),    64'(0));
        chk("mid.drop",  64'(out_valid), 64'(0));
        reset = 1'b1;

        // Randomized traffic against per-channel queues
        log_begin = 64'($urandom_range(0, 800));
        log_end   = 64'($urandom_range(0, 1600));
        do_reset();
        for (int i = 0; i < NCH; i++) q[i].delete();
        exp_ovf = '0; exp_cyc = '0; prev_stall = 1'b0; prev_ch = '0; prev_chan = '0;
        for (int t = 0; t < 1800; t++) begin
            if (prev_stall) begin
                chk("rnd.hold.valid", 64'(out_valid), 64'(1));
                chk("rnd.hold.ch",    64'(out_ch),    64'(prev_ch));
                chk("rnd.hold.chan",  64'(out_chan),  64'(prev_chan));
            end
            clear_in();
            if (t < 1500) begin
                out_ready = ($urandom_range(0, 1) == 1);
                line_mode = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 15) == 0) overflow_clr = 4'($urandom);
                for (int i = 0; i < NCH; i++)
                    if ($urandom_range(0, 9) < 3)
                        push(i, ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
            end else begin
                out_ready = 1'b1;
                line_mode = 1'b0;
            end
            if (out_valid && out_ready) begin
                c = int'(out_chan);
                if (q[c].size() == 0) begin
                    chk("rnd.spurious", 64'(out_valid), 64'(0));
                end else begin
                    chk("rnd.data", 64'(out_ch), 64'(q[c][0]));
                    void'(q[c].pop_front());
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && q[i].size() >= DEPTH) exp_ovf[i] = 1'b1;
                else if (overflow_clr[i])                 exp_ovf[i] = 1'b0;
                if (in_valid[i] && q[i].size() < DEPTH) q[i].push_back(in_ch[8*i +: 8]);
            end
            prev_stall = out_valid && !out_ready;
            prev_ch    = out_ch;
            prev_chan  = out_chan;
            nlog       = (exp_cyc >= log_begin) && (exp_cyc < log_end);
            exp_cyc    = exp_cyc + 64'd1;
            tick();
            chk("rnd.ovf",   64'(overflow), 64'(exp_ovf));
            chk("rnd.cycle", cycle,         exp_cyc);
            chk("rnd.log",   64'(log_en),   64'(nlog));
        end
        remaining = 0;
        for (int i = 0; i < NCH; i++) remaining += q[i].size();
        chk("rnd.drain", 64'(remaining), 64'(0));
        chk("rnd.idle",  64'(out_valid), 64'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
